// File: rtl/game_pmod_rx_multi.sv
// Gaming PMOD receiver for NUM_PADS daisy-chained pads: length check, link timeout, present flag.
// Define GAMEPAD_EDGE_EN to add the per-button pressed/released event outputs.
module game_pmod_rx_multi #(
  parameter int NUM_PADS       = 2,
  parameter int BIT_WIDTH      = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pmod_data,
  input  logic                          pmod_clk,
  input  logic                          pmod_latch,
  output logic [NUM_PADS*BIT_WIDTH-1:0] buttons,
  output logic                          frame_valid,
  output logic                          frame_err,
  output logic                          present
`ifdef GAMEPAD_EDGE_EN
  ,
  output logic [NUM_PADS*BIT_WIDTH-1:0] pressed,
  output logic [NUM_PADS*BIT_WIDTH-1:0] released
`endif
);

  localparam int FRAME_BITS = NUM_PADS * BIT_WIDTH;
  localparam int CW         = $clog2(FRAME_BITS + 2);
  localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] data_sq, clk_sq, latch_sq;
  logic                   clk_prev, latch_prev;
  logic                   data_s, clk_s, latch_s;
  logic                   clk_fall, latch_fall;
  logic [FRAME_BITS-1:0]  shift_reg, shifted, data_eff, frame_word;
  logic [CW-1:0]          bit_cnt, cnt_inc, cnt_eff;
  logic [TW-1:0]          tcnt;
  logic                   commit_ok, timeout_hit, btn_load;
  logic [FRAME_BITS-1:0]  btn_next;

  assign data_s     = data_sq[SYNC_STAGES-1];
  assign clk_s      = clk_sq[SYNC_STAGES-1];
  assign latch_s    = latch_sq[SYNC_STAGES-1];
  assign clk_fall   = clk_prev & ~clk_s;
  assign latch_fall = latch_prev & ~latch_s;

  // A clock fall in the same cycle as the latch fall is shifted in before the length check.
  assign shifted  = {shift_reg[FRAME_BITS-2:0], data_s};
  assign cnt_inc  = (bit_cnt == CW'(FRAME_BITS + 1)) ? bit_cnt : bit_cnt + CW'(1);
  assign cnt_eff  = clk_fall ? cnt_inc : bit_cnt;
  assign data_eff = clk_fall ? shifted : shift_reg;

  always_comb begin
    frame_word = '0;
    for (int p = 0; p < NUM_PADS; p++)
      frame_word[p*BIT_WIDTH +: BIT_WIDTH] = data_eff[(NUM_PADS-p)*BIT_WIDTH-1 -: BIT_WIDTH];
  end

  assign commit_ok   = latch_fall && (cnt_eff == CW'(FRAME_BITS));
  assign timeout_hit = !commit_ok && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign btn_load    = commit_ok || timeout_hit;
  assign btn_next    = commit_ok ? frame_word : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sq    <= '0;
      clk_sq     <= '0;
      latch_sq   <= '0;
      clk_prev   <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      data_sq    <= {data_sq[SYNC_STAGES-2:0], pmod_data};
      clk_sq     <= {clk_sq[SYNC_STAGES-2:0], pmod_clk};
      latch_sq   <= {latch_sq[SYNC_STAGES-2:0], pmod_latch};
      clk_prev   <= clk_s;
      latch_prev <= latch_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      tcnt        <= '0;
      buttons     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      present     <= 1'b0;
    end else begin
      frame_valid <= commit_ok;
      frame_err   <= latch_fall && !commit_ok;
      if (clk_fall)
        shift_reg <= shifted;
      if (latch_fall)
        bit_cnt <= '0;
      else if (clk_fall)
        bit_cnt <= cnt_inc;
      if (btn_load)
        buttons <= btn_next;
      if (commit_ok) begin
        tcnt    <= '0;
        present <= 1'b1;
      end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + TW'(1);
        if (timeout_hit)
          present <= 1'b0;
      end
    end
  end

`ifdef GAMEPAD_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed  <= '0;
      released <= '0;
    end else if (btn_load) begin
      pressed  <= btn_next & ~buttons;
      released <= ~btn_next & buttons;
    end else begin
      pressed  <= '0;
      released <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_game_pmod_rx_multi.sv
// Directed bench for game_pmod_rx_multi: two 12-bit pads, 100-cycle link timeout.
module tb_game_pmod_rx_multi;
  localparam int NP = 2;
  localparam int BW = 12;
  localparam int FB = NP * BW;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pmod_data = 1'b0, pmod_clk = 1'b0, pmod_latch = 1'b0;
  logic [FB-1:0] buttons;
  logic frame_valid, frame_err, present;
`ifdef GAMEPAD_EDGE_EN
  logic [FB-1:0] pressed, released;
`endif

  game_pmod_rx_multi #(
    .NUM_PADS(NP), .BIT_WIDTH(BW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
    .buttons(buttons), .frame_valid(frame_valid), .frame_err(frame_err),
    .present(present)
`ifdef GAMEPAD_EDGE_EN
    , .pressed(pressed), .released(released)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic got_v, got_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wire order: pad 0 first, each pad MSB first.
  function automatic logic wire_bit(input logic [FB-1:0] w, input int i);
    int p;
    int b;
    p = i / BW;
    b = BW - 1 - (i % BW);
    return w[p*BW + b];
  endfunction

  task automatic tx_bit(input logic b);
    @(negedge clk);
    pmod_data = b;
    pmod_clk  = 1'b1;
    @(negedge clk);
    pmod_clk  = 1'b0;
  endtask

  task automatic tx_frame(input logic [FB-1:0] w, input int n);
    for (int i = 0; i < n; i++) tx_bit(wire_bit(w, i % FB));
  endtask

  task automatic wait_result();
    got_v = 1'b0;
    got_e = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (frame_valid || frame_err) begin
        got_v = frame_valid;
        got_e = frame_err;
        return;
      end
    end
  endtask

  task automatic do_latch();
    @(negedge clk);
    pmod_latch = 1'b1;
    @(negedge clk);
    pmod_latch = 1'b0;
    wait_result();
  endtask

  initial begin
    int n;
    logic [FB-1:0] v;

    repeat (3) @(negedge clk);
    chk("rst_buttons", buttons, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_present", present, 0);
    rst_n = 1'b1;

    do_latch();
    chk("first_latch_err", got_e, 1);
    chk("first_latch_valid", got_v, 0);
    chk("first_latch_buttons", buttons, 0);

    tx_frame(24'hA0000F, 24);
    do_latch();
    chk("f1_valid", got_v, 1);
    chk("f1_err", got_e, 0);
    chk("f1_pad1", buttons[23:12], 12'hA00);
    chk("f1_pad0", buttons[11:0], 12'h00F);
    chk("f1_present", present, 1);
    @(posedge clk); #1;
    chk("f1_valid_one_cycle", frame_valid, 0);

    tx_frame(24'h5555AA, 23);
    do_latch();
    chk("short_err", got_e, 1);
    chk("short_valid", got_v, 0);
    chk("short_hold", buttons, 24'hA0000F);

    tx_frame(24'h123456, 24);
    do_latch();
    chk("f2_valid", got_v, 1);
    chk("f2_buttons", buttons, 24'h123456);

    tx_frame(24'hFFFFFF, 25);
    do_latch();
    chk("long_err", got_e, 1);
    chk("long_valid", got_v, 0);
    chk("long_hold", buttons, 24'h123456);

    v = 24'h5A5A5B;
    for (int i = 0; i < FB - 1; i++) tx_bit(wire_bit(v, i));
    @(negedge clk);
    pmod_data  = wire_bit(v, FB - 1);
    pmod_clk   = 1'b1;
    pmod_latch = 1'b1;
    @(negedge clk);
    pmod_clk   = 1'b0;
    pmod_latch = 1'b0;
    wait_result();
    chk("coinc_valid", got_v, 1);
    chk("coinc_err", got_e, 0);
    chk("coinc_buttons", buttons, v);

    n = 1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (present) n++;
      else break;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_present", present, 0);
    chk("timeout_buttons", buttons, 0);

    tx_frame(24'h00F0F0, 24);
    do_latch();
    chk("restore_valid", got_v, 1);
    chk("restore_present", present, 1);
    chk("restore_buttons", buttons, 24'h00F0F0);

    tx_frame(24'h000000, 24);
    do_latch();
    chk("zero_buttons", buttons, 0);
    tx_frame(24'h800001, 24);
    do_latch();
    chk("e1_buttons", buttons, 24'h800001);
`ifdef GAMEPAD_EDGE_EN
    chk("e1_pressed", pressed, 24'h800001);
    chk("e1_released", released, 0);
    @(posedge clk); #1;
    chk("e1_pressed_one_cycle", pressed, 0);
`endif
    tx_frame(24'h000001, 24);
    do_latch();
    chk("e2_buttons", buttons, 24'h000001);
`ifdef GAMEPAD_EDGE_EN
    chk("e2_released", released, 24'h800000);
    chk("e2_pressed", pressed, 0);
`endif

    for (int i = 0; i < 10; i++) tx_bit(1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_buttons", buttons, 0);
    chk("async_rst_present", present, 0);
    chk("async_rst_valid", frame_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_latch();
    chk("post_rst_err", got_e, 1);
    chk("post_rst_valid", got_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
